// File: rtl/pattern_detect_ctrl_pkg.sv
// Shared definitions for the front-panel pattern detection controller:
// controller states and default sizing.
package seq_ctrl_pkg;

   localparam int DEF_PAT_W   = 4;
   localparam int DEF_CNT_W   = 8;
   localparam int DEF_STRETCH = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARMED = 2'd1,
      HALT  = 2'd2
   } state_e;

endpackage

// File: rtl/pattern_detect_ctrl_if.sv
// Configuration, control and serial-bit bundle of pattern_detect_ctrl.
// The master side drives the i_* signals and the slave side drives the o_* signals.
interface pattern_detect_ctrl_if #(
   parameter int PAT_W = seq_ctrl_pkg::DEF_PAT_W,
   parameter int CNT_W = seq_ctrl_pkg::DEF_CNT_W
);
   import seq_ctrl_pkg::*;

   logic             i_cfg_valid;
   logic             o_cfg_ready;
   logic [PAT_W-1:0] i_cfg_pattern;
   logic [CNT_W-1:0] i_cfg_limit;
   logic             i_arm;
   logic             i_disarm;
   logic             i_bit_valid;
   logic             i_btn;
   logic             o_armed;
   logic             o_halted;
   logic             o_match;
   logic [CNT_W-1:0] o_match_count;
   logic             o_led;

   modport master (
      output i_cfg_valid, i_cfg_pattern, i_cfg_limit, i_arm, i_disarm, i_bit_valid, i_btn,
      input  o_cfg_ready, o_armed, o_halted, o_match, o_match_count, o_led
   );

   modport slave (
      input  i_cfg_valid, i_cfg_pattern, i_cfg_limit, i_arm, i_disarm, i_bit_valid, i_btn,
      output o_cfg_ready, o_armed, o_halted, o_match, o_match_count, o_led
   );

endinterface

// File: rtl/pattern_detect_ctrl_led_stretch.sv
// LED pulse stretcher: a trigger (re)loads a STRETCH-cycle down-counter and
// the output stays high while the counter is non-zero.
module led_stretch #(
   parameter int STRETCH = seq_ctrl_pkg::DEF_STRETCH
) (
   input  logic i_clock,
   input  logic i_reset,
   input  logic trigger,
   input  logic clear,
   output logic level
);
   import seq_ctrl_pkg::*;

   localparam int CW = $clog2(STRETCH + 1);
   localparam logic [CW-1:0] LOAD = CW'(STRETCH);

   logic [CW-1:0] cnt_reg;

   always_ff @(posedge i_clock) begin
      if (i_reset || clear) begin
         cnt_reg <= '0;
      end else if (trigger) begin
         cnt_reg <= LOAD;
      end else if (cnt_reg != '0) begin
         cnt_reg <= cnt_reg - CW'(1);
      end
   end

   assign level = (cnt_reg != '0);

endmodule

// File: rtl/pattern_detect_ctrl.sv
// Configurable serial-pattern detector with arm/disarm sequencing, match limit
// and stretched LED; define PAT_OVERLAP_EN to detect overlapping occurrences.
module pattern_detect_ctrl #(
   parameter int PAT_W   = seq_ctrl_pkg::DEF_PAT_W,
   parameter int CNT_W   = seq_ctrl_pkg::DEF_CNT_W,
   parameter int STRETCH = seq_ctrl_pkg::DEF_STRETCH
) (
   input logic                  i_clock,
   input logic                  i_reset,
   pattern_detect_ctrl_if.slave bus
);
   import seq_ctrl_pkg::*;

   localparam logic [1:0] S_IDLE  = IDLE;
   localparam logic [1:0] S_ARMED = ARMED;
   localparam logic [1:0] S_HALT  = HALT;
   localparam int FILL_W = $clog2(PAT_W + 1);
   localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

   logic [1:0]        state_reg, state_next;
   logic [PAT_W-1:0]  pattern_reg, hist_reg, hist_next, match_bits;
   logic [CNT_W-1:0]  limit_reg, count_reg, count_next;
   logic [FILL_W-1:0] fill_reg, fill_next, fill_after;
   logic              match_reg;
   logic              cfg_xfer, arm_go, bit_go, hit, halt_hit, led_level;

   assign cfg_xfer = bus.i_cfg_valid && (state_reg == S_IDLE);
   assign arm_go   = bus.i_arm && (state_reg == S_IDLE);
   // A disarm wins over a same-cycle bit, so that bit never reaches the history.
   assign bit_go   = bus.i_bit_valid && (state_reg == S_ARMED) && !bus.i_disarm;

   assign hist_next  = {hist_reg[PAT_W-2:0], bus.i_btn};
   assign fill_next  = (fill_reg == FILL_FULL) ? FILL_FULL : fill_reg + FILL_W'(1);
   assign count_next = (&count_reg) ? count_reg : count_reg + CNT_W'(1);

   for (genvar gi = 0; gi < PAT_W; gi++) begin : g_cmp
      assign match_bits[gi] = ~(hist_next[gi] ^ pattern_reg[gi]);
   end

   assign hit      = bit_go && (fill_next == FILL_FULL) && (&match_bits);
   assign halt_hit = hit && (limit_reg != '0) && (count_next == limit_reg);

`ifdef PAT_OVERLAP_EN
   assign fill_after = fill_next;
`else
   assign fill_after = hit ? '0 : fill_next;
`endif

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         S_IDLE:  if (bus.i_arm) state_next = S_ARMED;
         S_ARMED: begin
            if (bus.i_disarm)  state_next = S_IDLE;
            else if (halt_hit) state_next = S_HALT;
         end
         S_HALT:  if (bus.i_disarm) state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         state_reg   <= S_IDLE;
         pattern_reg <= '0;
         limit_reg   <= '0;
         hist_reg    <= '0;
         fill_reg    <= '0;
         count_reg   <= '0;
         match_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         match_reg <= hit;
         if (cfg_xfer) begin
            pattern_reg <= bus.i_cfg_pattern;
            limit_reg   <= bus.i_cfg_limit;
         end
         if (arm_go) begin
            hist_reg  <= '0;
            fill_reg  <= '0;
            count_reg <= '0;
         end else if (bit_go) begin
            hist_reg <= hist_next;
            fill_reg <= fill_after;
            if (hit) count_reg <= count_next;
         end
      end
   end

   led_stretch #(.STRETCH(STRETCH)) u_led (
      .i_clock (i_clock),
      .i_reset (i_reset),
      .trigger (hit),
      .clear   (arm_go),
      .level   (led_level)
   );

   assign bus.o_cfg_ready   = (state_reg == S_IDLE);
   assign bus.o_armed       = (state_reg == S_ARMED);
   assign bus.o_halted      = (state_reg == S_HALT);
   assign bus.o_match       = match_reg;
   assign bus.o_match_count = count_reg;
   assign bus.o_led         = led_level;

endmodule

// File: tb/tb_pattern_detect_ctrl.sv
// Self-checking bench for pattern_detect_ctrl: directed scenarios plus a
// randomized run against a queue-based reference model (honours PAT_OVERLAP_EN).
module tb_pattern_detect_ctrl;
   localparam int PAT_W   = 4;
   localparam int CNT_W   = 8;
   localparam int STRETCH = 4;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   pattern_detect_ctrl_if #(.PAT_W(PAT_W), .CNT_W(CNT_W)) bus ();

   pattern_detect_ctrl #(.PAT_W(PAT_W), .CNT_W(CNT_W), .STRETCH(STRETCH)) dut (
      .i_clock (clk),
      .i_reset (rst),
      .bus     (bus)
   );

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   bit verbose = 1'b1;

   // Reference model: state 0=idle 1=armed 2=halt, bits seen since arm/last match.
   int         m_state;
   logic [3:0] m_pat;
   logic [7:0] m_lim;
   logic [7:0] m_count;
   logic       m_match;
   bit         m_have;
   int         m_last;
   bit         m_q[$];

   function automatic logic m_led();
      return m_have && ((cyc - m_last) < STRETCH);
   endfunction

   task automatic model_edge(input logic r, input logic cv, input logic [3:0] p,
                             input logic [7:0] l, input logic a, input logic d,
                             input logic bv, input logic b);
      logic [3:0] w;
      cyc++;
      m_match = 1'b0;
      if (r) begin
         m_state = 0; m_pat = '0; m_lim = '0; m_count = '0; m_have = 0;
         m_q.delete();
         return;
      end
      case (m_state)
         0: begin
            if (cv) begin m_pat = p; m_lim = l; end
            if (a) begin m_state = 1; m_q.delete(); m_count = '0; m_have = 0; end
         end
         1: begin
            if (d) m_state = 0;
            else if (bv) begin
               m_q.push_back(b);
               if (m_q.size() > PAT_W) void'(m_q.pop_front());
               if (m_q.size() == PAT_W) begin
                  w = '0;
                  foreach (m_q[k]) w = {w[2:0], logic'(m_q[k])};
                  if (w == m_pat) begin
                     m_match = 1'b1;
                     if (m_count != 8'hFF) m_count = m_count + 8'd1;
                     m_have = 1; m_last = cyc;
`ifndef PAT_OVERLAP_EN
                     m_q.delete();
`endif
                     if (m_lim != 0 && m_count == m_lim) m_state = 2;
                  end
               end
            end
         end
         default: if (d) m_state = 0;
      endcase
   endtask

   task automatic step(input logic r, input logic cv, input logic [3:0] p,
                       input logic [7:0] l, input logic a, input logic d,
                       input logic bv, input logic b);
      rst = r;
      bus.i_cfg_valid = cv; bus.i_cfg_pattern = p; bus.i_cfg_limit = l;
      bus.i_arm = a; bus.i_disarm = d; bus.i_bit_valid = bv; bus.i_btn = b;
      @(posedge clk);
      model_edge(r, cv, p, l, a, d, bv, b);
      #1;
      if (verbose && m_match) $display("cycle %0d: match, count %0d", cyc, m_count);
   endtask

   task automatic idle();                                   step(0, 0, 4'h0, 8'h0, 0, 0, 0, 0); endtask
   task automatic bit_in(input logic b);                    step(0, 0, 4'h0, 8'h0, 0, 0, 1, b); endtask
   task automatic do_disarm();                              step(0, 0, 4'h0, 8'h0, 0, 1, 0, 0); endtask
   task automatic do_arm(input logic [3:0] p, input logic [7:0] l);
      $display("cycle %0d: config %b limit %0d + arm", cyc + 1, p, l);
      step(0, 1, p, l, 1, 0, 0, 0);
   endtask

   task automatic test_reset();
      logic [12:0] got;
      step(1, 0, 4'h0, 8'h0, 0, 0, 0, 0);
      got = {bus.o_cfg_ready, bus.o_armed, bus.o_halted, bus.o_match, bus.o_led, bus.o_match_count};
      checks++;
      if (got !== {5'b10000, 8'd0}) begin errors++; $display("FAIL reset_initial got=%b exp=%b", got, {5'b10000, 8'd0}); end
      do_arm(4'b1010, 8'd0);
      for (int i = 0; i < 40 && m_count != 8'd3; i++) bit_in(logic'(i % 2 == 0));
      checks++;
      if (bus.o_match_count !== 8'd3 || bus.o_armed !== 1'b1) begin
         errors++; $display("FAIL reset_precount count=%0d armed=%b exp count=3 armed=1", bus.o_match_count, bus.o_armed);
      end
      step(1, 0, 4'h0, 8'h0, 0, 0, 0, 0);
      got = {bus.o_cfg_ready, bus.o_armed, bus.o_halted, bus.o_match, bus.o_led, bus.o_match_count};
      checks++;
      if (got !== {5'b10000, 8'd0}) begin errors++; $display("FAIL reset_mid_armed got=%b exp=%b", got, {5'b10000, 8'd0}); end
      // Pattern register resets to 0000: arming without config must match four zeros.
      step(0, 0, 4'h0, 8'h0, 1, 0, 0, 0);
      for (int i = 0; i < 4; i++) bit_in(1'b0);
      checks++;
      if (bus.o_match !== 1'b1 || bus.o_match_count !== 8'd1) begin
         errors++; $display("FAIL reset_pattern_zero match=%b count=%0d exp match=1 count=1", bus.o_match, bus.o_match_count);
      end
      do_disarm();
   endtask

   task automatic test_overlap();
      logic [5:0] mask, exp_mask;
      logic [7:0] exp_cnt;
      do_arm(4'b1010, 8'd0);
      mask = '0;
      for (int i = 0; i < 6; i++) begin
         bit_in(logic'(i % 2 == 0));
         mask[i] = bus.o_match;
      end
`ifdef PAT_OVERLAP_EN
      exp_mask = 6'b101000; exp_cnt = 8'd2;
`else
      exp_mask = 6'b001000; exp_cnt = 8'd1;
`endif
      checks++;
      if (mask !== exp_mask) begin errors++; $display("FAIL overlap_positions got=%b exp=%b", mask, exp_mask); end
      checks++;
      if (bus.o_match_count !== exp_cnt) begin errors++; $display("FAIL overlap_count got=%0d exp=%0d", bus.o_match_count, exp_cnt); end
      do_disarm();
   endtask

   task automatic test_limit_halt();
      int   halt_idx, exp_idx;
      logic same_match;
      logic [2:0] got3;
      logic [10:0] got11;
      halt_idx = -1; same_match = 1'b0;
      do_arm(4'b1010, 8'd2);
      for (int i = 0; i < 8; i++) begin
         bit_in(logic'(i % 2 == 0));
         if (bus.o_halted === 1'b1 && halt_idx < 0) begin halt_idx = i; same_match = bus.o_match; end
      end
`ifdef PAT_OVERLAP_EN
      exp_idx = 5;
`else
      exp_idx = 7;
`endif
      checks++;
      if (halt_idx != exp_idx || same_match !== 1'b1) begin
         errors++; $display("FAIL limit_halt_edge halt_bit=%0d match=%b exp halt_bit=%0d match=1", halt_idx, same_match, exp_idx);
      end
      for (int i = 0; i < 4; i++) begin
         bit_in(logic'(i % 2 == 0));
         got11 = {bus.o_halted, bus.o_match, bus.o_match_count, 1'b0};
         checks++;
         if (got11 !== {2'b10, 8'd2, 1'b0}) begin
            errors++; $display("FAIL halt_hold halted=%b match=%b count=%0d exp 1 0 2", bus.o_halted, bus.o_match, bus.o_match_count);
         end
      end
      do_disarm();
      got3 = {bus.o_cfg_ready, bus.o_halted, bus.o_armed};
      checks++;
      if (got3 !== 3'b100 || bus.o_match_count !== 8'd2) begin
         errors++; $display("FAIL halt_disarm flags=%b count=%0d exp flags=100 count=2", got3, bus.o_match_count);
      end
   endtask

   task automatic test_cfg_arm_same();
      logic [3:0] s;
      s = 4'b0110;
      do_arm(s, 8'd0);
      for (int i = 0; i < 4; i++) begin
         bit_in(s[3-i]);
         checks++;
         if (bus.o_match !== logic'(i == 3)) begin
            errors++; $display("FAIL cfg_arm_match bit=%0d got=%b exp=%b", i, bus.o_match, logic'(i == 3));
         end
      end
      idle();
      checks++;
      if (bus.o_match !== 1'b0 || bus.o_match_count !== 8'd1) begin
         errors++; $display("FAIL cfg_arm_pulse match=%b count=%0d exp match=0 count=1", bus.o_match, bus.o_match_count);
      end
   endtask

   task automatic test_disarm_collide();
      logic [3:0] got;
      bit_in(1'b0); bit_in(1'b1); bit_in(1'b1);
      step(0, 0, 4'h0, 8'h0, 0, 1, 1, 0);
      got = {bus.o_match, bus.o_cfg_ready, bus.o_armed, bus.o_halted};
      checks++;
      if (got !== 4'b0100 || bus.o_match_count !== 8'd1) begin
         errors++; $display("FAIL disarm_collide flags=%b count=%0d exp flags=0100 count=1", got, bus.o_match_count);
      end
      idle();
      checks++;
      if (bus.o_match !== 1'b0) begin errors++; $display("FAIL disarm_collide_late got=%b exp=0", bus.o_match); end
   endtask

   task automatic test_led_stretch();
      int run, max_run, exp_run;
      do_arm(4'b1010, 8'd0);
      bit_in(1); bit_in(0); bit_in(1); bit_in(0);
      do_disarm();
      checks++;
      if (bus.o_led !== 1'b1) begin errors++; $display("FAIL led_in_idle got=%b exp=1", bus.o_led); end
      do_arm(4'b1010, 8'd0);
      checks++;
      if (bus.o_led !== 1'b0) begin errors++; $display("FAIL led_arm_clear got=%b exp=0", bus.o_led); end
      run = 0; max_run = 0;
      for (int i = 0; i < 16; i++) begin
         if (i < 6) bit_in(logic'(i % 2 == 0)); else idle();
         if (bus.o_led === 1'b1) run++; else run = 0;
         if (run > max_run) max_run = run;
      end
`ifdef PAT_OVERLAP_EN
      exp_run = 6;
`else
      exp_run = 4;
`endif
      checks++;
      if (max_run != exp_run || bus.o_led !== 1'b0) begin
         errors++; $display("FAIL led_run got=%0d end=%b exp=%0d end=0", max_run, bus.o_led, exp_run);
      end
      do_disarm();
   endtask

   task automatic test_saturate();
      verbose = 1'b0;
      do_arm(4'b0000, 8'd0);
      for (int i = 0; i < 1100; i++) bit_in(1'b0);
      verbose = 1'b1;
      checks++;
      if (bus.o_match_count !== 8'hFF || m_count !== 8'hFF) begin
         errors++; $display("FAIL saturate got=%0d exp=255", bus.o_match_count);
      end
      do_disarm();
   endtask

   task automatic test_random();
      logic [3:0]  pat;
      logic [12:0] got, exp;
      logic        b;
      for (int r = 0; r < 10; r++) begin
         do_disarm();
         pat = 4'($urandom);
         do_arm(pat, 8'($urandom_range(0, 3)));
         for (int c = 0; c < 150; c++) begin
            b = ($urandom_range(0, 3) != 0) ? m_pat[3 - (c % 4)] : logic'($urandom_range(0, 1));
            step(0, logic'($urandom_range(0, 19) == 0), 4'($urandom), 8'($urandom_range(0, 3)),
                 logic'($urandom_range(0, 29) == 0), logic'($urandom_range(0, 59) == 0),
                 logic'($urandom_range(0, 3) != 0), b);
            got = {bus.o_cfg_ready, bus.o_armed, bus.o_halted, bus.o_match, bus.o_led, bus.o_match_count};
            exp = {logic'(m_state == 0), logic'(m_state == 1), logic'(m_state == 2), m_match, m_led(), m_count};
            checks++;
            if (got !== exp) begin
               errors++; $display("FAIL random cycle=%0d got=%b exp=%b (ready,armed,halted,match,led,count)", cyc, got, exp);
            end
         end
      end
   endtask

   initial begin
      rst = 1'b1;
      bus.i_cfg_valid = 0; bus.i_cfg_pattern = '0; bus.i_cfg_limit = '0;
      bus.i_arm = 0; bus.i_disarm = 0; bus.i_bit_valid = 0; bus.i_btn = 0;
      test_reset();
      test_overlap();
      test_limit_halt();
      test_cfg_arm_same();
      test_disarm_collide();
      test_led_stretch();
      test_saturate();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pattern_detect_ctrl.md
# pattern_detect_ctrl

Programmable serial-pattern detection controller for the button/LED front panel. It accepts a pattern through a valid/ready configuration handshake, arms and disarms detection, and scans qualified input bits for the pattern. It counts matches up to an optional limit and drives a stretched LED indication. It replaces hard-wired per-pattern detector FSMs with a single configurable, sequenced resource.

## Interface
- PAT_W, 4: pattern length in bits (2..16).
- CNT_W, 8: match counter width.
- STRETCH, 4: LED on-time in cycles per match (≥1).
- i_clock  in  1  clock, all logic on rising edge.
- i_reset  in  1  reset, synchronous, active-high.
- i_cfg_valid  in  1  configuration request.
- o_cfg_ready  out  1  high only in IDLE.
- i_cfg_pattern  in  PAT_W  pattern; MSB is the first bit expected.
- i_cfg_limit  in  CNT_W  match limit; 0 = unlimited.
- i_arm  in  1  start detection (honoured in IDLE only).
- i_disarm  in  1  stop detection (honoured in ARMED and HALT).
- i_bit_valid  in  1  qualifies i_btn as one serial bit.
- i_btn  in  1  serial data bit.
- o_armed  out  1  high in ARMED.
- o_halted  out  1  high in HALT.
- o_match  out  1  one-cycle pulse per detected match.
- o_match_count  out  CNT_W  matches since last arm.
- o_led  out  1  stretched match indication.

## Operation
- States: IDLE, ARMED, HALT. Reset → IDLE.
- Config: transfer when i_cfg_valid && o_cfg_ready. Latches pattern and limit.
- Arm: i_arm in IDLE → ARMED next cycle. Clears history shift register, fill count, o_match_count and o_led.
  - Config transfer and i_arm in the same cycle: the arm uses the newly transferred pattern and limit.
- In ARMED, each cycle with i_bit_valid shifts i_btn into history (LSB in). Fill count increments, saturating at PAT_W.
- Match when fill count (including this bit) = PAT_W and history (including this bit) equals the pattern.
- On match:
  - o_match_count increments, saturating at all-ones.
  - If the limit is nonzero and the new count equals the limit → HALT.
- HALT: no bits accepted; count and flags held; only i_disarm → IDLE.
- i_disarm in ARMED/HALT → IDLE next cycle. It has priority over a same-cycle bit, which is discarded and cannot match.
- i_arm outside IDLE, i_disarm in IDLE, and bits outside ARMED are ignored.
- o_match_count retains its value in IDLE until the next arm.

## Timing
- Reset values: o_cfg_ready=1, o_armed=0, o_halted=0, o_match=0, o_match_count=0, o_led=0. Pattern and limit reset to 0.
- o_match is registered. It is high in cycle N+1 when the completing bit is sampled in cycle N. The count updates in the same cycle N+1.
- State flags are registered: the new state is visible the cycle after the causing event. A limit-hit sets o_halted in the same cycle as o_match.
- o_led rises with o_match and stays high STRETCH cycles. A match during stretch reloads the full STRETCH.
- o_led keeps stretching after a transition to HALT or IDLE; it is cleared only by reset or arm.
- Back-to-back valid bits are accepted every cycle with no stall.

## Configuration
- PAT_OVERLAP_EN defined: history and fill count are retained after a match, so overlapping occurrences are detected. Pattern 1010 on 1010101... matches every 2 bits after the first match.
- PAT_OVERLAP_EN undefined: fill count clears on match, so the next match needs PAT_W fresh bits (non-overlapping).

## Structure
- Package seq_ctrl_pkg: state enum (IDLE, ARMED, HALT) and default PAT_W/CNT_W/STRETCH constants.
- Sub-module led_stretch: reloadable down-counter. Inputs: trigger and clear. Output: level. Parameter: STRETCH.
- Detection, history, and counter logic live in pattern_detect_ctrl.

## Test plan
- Reset mid-ARMED with count 3 → all outputs at reset values next cycle; o_cfg_ready=1.
- Pattern 1010, limit 0, arm, bits 1,0,1,0,1,0:
  - With PAT_OVERLAP_EN: matches after bits 4 and 6, count 2.
  - Without PAT_OVERLAP_EN: one match after bit 4, count 1.
- Pattern 1010, limit 2, stream 10101010 (non-overlap) → second match sets o_halted. Further valid bits leave count at 2. i_disarm → IDLE.
- Config 0110 and i_arm in the same cycle, then bits 0,1,1,0 → one o_match, 1 cycle after the last bit.
- Last matching bit coincides with i_disarm → no o_match, count unchanged, IDLE next cycle.
- STRETCH=4, two matches 2 cycles apart (overlap on) → o_led high 6 consecutive cycles, then low.
